// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access unit: DMType codes, FSM states
// and small decode helpers used by both the controller and the lane unit.
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } dm_state_e;

    function automatic logic dm_is_half(input logic [2:0] t);
        return (t == DM_HALF) || (t == DM_HALF_U);
    endfunction

    function automatic logic dm_is_byte(input logic [2:0] t);
        return (t == DM_BYTE) || (t == DM_BYTE_U);
    endfunction

    // Codes 101-111 behave as a full word access.
    function automatic logic dm_is_word(input logic [2:0] t);
        return (t == DM_WORD) || (t > DM_BYTE_U);
    endfunction

    function automatic logic dm_is_signed(input logic [2:0] t);
        return (t == DM_HALF) || (t == DM_BYTE);
    endfunction

    // Lane offset with the bits a given access width cannot use forced to zero.
    function automatic logic [1:0] dm_lane(input logic [2:0] t, input logic [1:0] lo);
        if (dm_is_byte(t))
            return lo;
        else if (dm_is_half(t))
            return {lo[1], 1'b0};
        else
            return 2'b00;
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] lo);
        if (dm_is_byte(t))
            return 1'b0;
        else if (dm_is_half(t))
            return lo[0];
        else
            return lo != 2'b00;
    endfunction

endpackage

// File: rtl/dm_access_unit_lane.sv
// Combinational lane logic: extracts and extends load data, and merges
// sub-word store data into a previously read word.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [2:0]  dmtype,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic        sext;

    always_comb begin
        half_v   = lane[1] ? rword[31:16] : rword[15:0];
        byte_v   = rword[{lane, 3'b000} +: 8];
        sext     = dm_is_signed(dmtype);
        load_val = rword;
        merged   = wdata;
        if (dm_is_half(dmtype)) begin
            load_val = {{16{sext & half_v[15]}}, half_v};
            merged   = rword;
            merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end else if (dm_is_byte(dmtype)) begin
            load_val = {{24{sext & byte_v[7]}}, byte_v};
            merged   = rword;
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
        end
    end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit: sequences loads, word stores and read-modify-write
// sub-word stores against a word-wide RAM. Optional macro: DM_MISALIGN_TRAP_EN.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_dmtype,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    dm_state_e         state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        dmtype_q, dmtype_d;
    logic [1:0]        lane_q, lane_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_misaligned;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

`ifdef DM_MISALIGN_TRAP_EN
    assign req_misaligned = dm_misaligned(req_dmtype, req_addr[1:0]);
`else
    assign req_misaligned = 1'b0;
`endif

    dm_lane_unit u_lane (
        .dmtype   (dmtype_q),
        .lane     (lane_q),
        .rword    (mem_rdata),
        .wdata    (data_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        dmtype_d = dmtype_q;
        lane_d   = lane_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    dmtype_d = req_dmtype;
                    lane_d   = dm_lane(req_dmtype, req_addr[1:0]);
                    addr_d   = req_addr[MEM_AW+1:2];
                    data_d   = req_wdata;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    if (req_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_we && dm_is_word(req_dmtype)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT: begin
                // Stores reuse data_q to carry the merged word into WRITE.
                if (we_q) begin
                    data_d  = merged;
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q     <= we_d;
        dmtype_q <= dmtype_d;
        lane_q   <= lane_d;
        data_q   <= data_d;
    end

    // RAM strobes are gated by rst so an abandoned WRITE never reaches memory.
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign mem_en    = ((state_q == ST_READ) || (state_q == ST_WRITE)) && !rst;
    assign mem_we    = (state_q == ST_WRITE) && !rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = (state_q == ST_WRITE) ? data_q : 32'h0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed scoreboard bench for dm_access_unit with a behavioural synchronous RAM.
module tb_dm_access_unit;
    import dm_pkg::*;

    localparam int MEM_AW = 10;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_dmtype;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    dm_access_unit #(.MEM_AW(MEM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_dmtype (req_dmtype),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [0:(1<<MEM_AW)-1];
    int n_rd = 0;
    int n_wr = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                n_wr <= n_wr + 1;
            end else begin
                mem_rdata <= ram[mem_addr];
                n_rd <= n_rd + 1;
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request/response; hold>0 keeps rsp_ready low that many cycles while
    // presenting a competing store that must be ignored.
    task automatic access(input string tag, input logic we, input logic [2:0] t,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int hold);
        int   lat;
        exp_t e;
        lat = 0;
        while (!req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_dmtype = t;
        req_addr   = addr;
        req_wdata  = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        check({tag, "/latency"}, 32'(lat), 32'(e.lat));
        check({tag, "/rdata"}, rsp_rdata, e.rdata);
        check({tag, "/err"}, 32'(rsp_err), 32'(e.err));
        repeat (hold) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_dmtype = DM_WORD;
            req_addr   = 32'hC;
            req_wdata  = 32'h5555_5555;
            @(negedge clk);
            check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "/hold_rdata"}, rsp_rdata, e.rdata);
            check({tag, "/hold_err"}, 32'(rsp_err), 32'(e.err));
            check({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "/post_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "/post_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0;
        logic seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_dmtype = DM_WORD;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst/req_ready", 32'(req_ready), 32'd0);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_rdata", rsp_rdata, 32'd0);
        check("rst/rsp_err", 32'(rsp_err), 32'd0);
        check("rst/mem_en", 32'(mem_en), 32'd0);
        check("rst/mem_we", 32'(mem_we), 32'd0);
        check("rst/mem_addr", 32'(mem_addr), 32'd0);
        check("rst/mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst/ready_after", 32'(req_ready), 32'd1);

        rd0 = n_rd; wr0 = n_wr;
        access("sw8", 1'b1, DM_WORD, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0);
        check("sw8/ram", ram[2], 32'hDEAD_BEEF);
        check("sw8/nrd", 32'(n_rd - rd0), 32'd0);
        check("sw8/nwr", 32'(n_wr - wr0), 32'd1);
        access("lw8", 1'b0, DM_WORD, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 0);

        access("sw4", 1'b1, DM_WORD, 32'h4, 32'h1122_3344, 32'h0, 1'b0, 2, 0);
        rd0 = n_rd; wr0 = n_wr;
        access("sb6", 1'b1, DM_BYTE, 32'h6, 32'h1234_56AA, 32'h0, 1'b0, 4, 0);
        check("sb6/ram", ram[1], 32'h11AA_3344);
        check("sb6/nrd", 32'(n_rd - rd0), 32'd1);
        check("sb6/nwr", 32'(n_wr - wr0), 32'd1);

        access("sw0", 1'b1, DM_WORD, 32'h0, 32'h80F1_7F01, 32'h0, 1'b0, 2, 0);
        access("lb2", 1'b0, DM_BYTE, 32'h2, 32'h0, 32'hFFFF_FFF1, 1'b0, 3, 0);
        access("lbu2", 1'b0, DM_BYTE_U, 32'h2, 32'h0, 32'h0000_00F1, 1'b0, 3, 0);
        access("lh2", 1'b0, DM_HALF, 32'h2, 32'h0, 32'hFFFF_80F1, 1'b0, 3, 0);
        access("lhu2", 1'b0, DM_HALF_U, 32'h2, 32'h0, 32'h0000_80F1, 1'b0, 3, 0);
        access("lb1", 1'b0, DM_BYTE, 32'h1, 32'h0, 32'h0000_007F, 1'b0, 3, 0);
        access("lh0", 1'b0, DM_HALF, 32'h0, 32'h0, 32'h0000_7F01, 1'b0, 3, 0);
        access("lb3", 1'b0, DM_BYTE, 32'h3, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 0);
        access("lbu3", 1'b0, DM_BYTE_U, 32'h3, 32'h0, 32'h0000_0080, 1'b0, 3, 0);

        access("shA", 1'b1, DM_HALF, 32'hA, 32'hFFFF_BEEF, 32'h0, 1'b0, 4, 0);
        check("shA/ram", ram[2], 32'hBEEF_BEEF);
        access("lw8_t7", 1'b0, 3'b111, 32'h8, 32'h0, 32'hBEEF_BEEF, 1'b0, 3, 0);

        rd0 = n_rd; wr0 = n_wr;
`ifdef DM_MISALIGN_TRAP_EN
        access("lw5", 1'b0, DM_WORD, 32'h5, 32'h0, 32'h0, 1'b1, 1, 0);
        access("sw6", 1'b1, DM_WORD, 32'h6, 32'hCAFE_F00D, 32'h0, 1'b1, 1, 0);
        access("lh7", 1'b0, DM_HALF, 32'h7, 32'h0, 32'h0, 1'b1, 1, 0);
        check("mis/ram", ram[1], 32'h11AA_3344);
        check("mis/nrd", 32'(n_rd - rd0), 32'd0);
        check("mis/nwr", 32'(n_wr - wr0), 32'd0);
`else
        access("lw5", 1'b0, DM_WORD, 32'h5, 32'h0, 32'h11AA_3344, 1'b0, 3, 0);
        access("sw6", 1'b1, DM_WORD, 32'h6, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 0);
        access("lh7", 1'b0, DM_HALF, 32'h7, 32'h0, 32'hFFFF_CAFE, 1'b0, 3, 0);
        check("mis/ram", ram[1], 32'hCAFE_F00D);
        check("mis/nrd", 32'(n_rd - rd0), 32'd2);
        check("mis/nwr", 32'(n_wr - wr0), 32'd1);
`endif

        wr0 = n_wr;
        access("stall", 1'b0, DM_WORD, 32'h8, 32'h0, 32'hBEEF_BEEF, 1'b0, 3, 5);
        check("stall/nwr", 32'(n_wr - wr0), 32'd0);

        access("sw4b", 1'b1, DM_WORD, 32'h4, 32'h1122_3344, 32'h0, 1'b0, 2, 0);
        wr0 = n_wr;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_dmtype = DM_BYTE;
        req_addr   = 32'h6;
        req_wdata  = 32'h0000_00AA;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rstw/in_write", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rstw/mem_we_gated", 32'(mem_we), 32'd0);
        check("rstw/mem_en_gated", 32'(mem_en), 32'd0);
        check("rstw/ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw/ready_after", 32'(req_ready), 32'd1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("rstw/no_rsp", 32'(seen), 32'd0);
        check("rstw/nwr", 32'(n_wr - wr0), 32'd0);
        check("rstw/ram", ram[1], 32'h1122_3344);
        check("sb/empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
